// File: rtl/core_ctrl_pkg.sv
// Phase encoding and defaults shared by the core dispatch sequencer and the
// GPIO status block that displays its phase.
package core_ctrl_pkg;

   localparam logic [1:0] PHASE_IDLE  = 2'b00;
   localparam logic [1:0] PHASE_START = 2'b01;
   localparam logic [1:0] PHASE_WAIT  = 2'b10;
   localparam logic [1:0] PHASE_DONE  = 2'b11;

   localparam int NUM_CORES_DEF = 4;

   // State values equal the phase code, so the state register drives phase directly.
   typedef enum logic [1:0] {
      ST_IDLE  = PHASE_IDLE,
      ST_START = PHASE_START,
      ST_WAIT  = PHASE_WAIT,
      ST_DONE  = PHASE_DONE
   } disp_state_e;

endpackage

// File: rtl/core_wait_timer.sv
// Wait-phase cycle counter: clear has priority over enable, and terminal count
// flags the cycle whose increment would reach LIMIT.
module core_wait_timer #(
   parameter int CNT_W = 16,
   parameter int LIMIT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_nxt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_nxt_o = cnt_q + CNT_W'(1);
   assign tc_o      = (cnt_nxt_o == CNT_W'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_nxt_o;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/core_dispatch_ctrl.sv
// Launches the enabled compute cores, collects their done indications and
// reports phase, completion and timeout; every output is a register.
module core_dispatch_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int NUM_CORES      = NUM_CORES_DEF,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 launch,
   input  logic [NUM_CORES-1:0] core_enable,
   input  logic [NUM_CORES-1:0] core_done,
   output logic [NUM_CORES-1:0] core_start,
   output logic [1:0]           phase,
   output logic                 busy,
   output logic                 all_done,
   output logic                 timeout,
   output logic [NUM_CORES-1:0] done_mask,
   output logic [CNT_W-1:0]     cycle_count
);

   disp_state_e          state_q;
   logic [NUM_CORES-1:0] run_mask_q, core_start_q, done_mask_q, done_mask_d;
   logic                 busy_q, all_done_q, timeout_q;
   logic [CNT_W-1:0]     cycle_count_q, cnt_nxt;
   logic                 tmr_clr, tmr_en, tmr_tc, complete;

   // Masking with run_mask keeps disabled cores out of done_mask for good.
   assign done_mask_d = done_mask_q | (core_done & run_mask_q);
   assign complete    = (done_mask_d == run_mask_q);
   assign tmr_clr     = (state_q == ST_START);
   assign tmr_en      = (state_q == ST_WAIT);

   core_wait_timer #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .cnt_nxt_o (cnt_nxt),
      .tc_o      (tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         run_mask_q    <= '0;
         core_start_q  <= '0;
         done_mask_q   <= '0;
         busy_q        <= 1'b0;
         all_done_q    <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         core_start_q <= '0;
         all_done_q   <= 1'b0;
         timeout_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (launch && |core_enable) begin
                  run_mask_q   <= core_enable;
                  core_start_q <= core_enable;
                  busy_q       <= 1'b1;
                  state_q      <= ST_START;
               end
            end
            ST_START: begin
               done_mask_q <= '0;
               state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
               done_mask_q <= done_mask_d;
               // Completion is tested first so it wins over a coincident timeout.
               if (complete) begin
                  cycle_count_q <= cnt_nxt;
                  all_done_q    <= 1'b1;
                  state_q       <= ST_DONE;
               end else if (tmr_tc) begin
                  cycle_count_q <= cnt_nxt;
                  timeout_q     <= 1'b1;
                  state_q       <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign phase       = state_q;
   assign busy        = busy_q;
   assign core_start  = core_start_q;
   assign all_done    = all_done_q;
   assign timeout     = timeout_q;
   assign done_mask   = done_mask_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: doc/core_dispatch_ctrl.md
Name: core_dispatch_ctrl

Overview:
Upstream sequencer that launches the accelerator compute cores and tracks their completion. It issues per-core start pulses and collects per-core done indications. It reports run phase, completion and timeout status to the status/LED stage. Its 2-bit phase output uses the same IDLE/START_CORES/WAIT_FOR_DONE/DONE_STATE encoding the GPIO status block displays.

Parameters:
NUM_CORES, 4, number of compute cores controlled
TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort; legal range 1..65535
CNT_W, 16, width of the wait counter and cycle_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
launch  input  1  single-cycle run request
core_enable  input  NUM_CORES  cores participating in the run; sampled on the accepted launch
core_done  input  NUM_CORES  per-core done (pulse or level); captured stickily
core_start  output  NUM_CORES  one-cycle start pulse to each enabled core
phase  output  2  00 IDLE, 01 START_CORES, 10 WAIT_FOR_DONE, 11 DONE_STATE
busy  output  1  high whenever phase != IDLE
all_done  output  1  one-cycle pulse: every enabled core reported done
timeout  output  1  one-cycle pulse: run aborted by timeout
done_mask  output  NUM_CORES  captured done bits of the current or last run
cycle_count  output  CNT_W  number of WAIT cycles of the last run; held until next launch

Behaviour:
- All outputs are registered. Reset forces state IDLE and drives every output and internal register to 0. Reset mid-run aborts with no start pulse, no all_done and no timeout.
- IDLE:
  - launch=1 and |core_enable=1: latch run_mask=core_enable, go to START.
  - launch with core_enable=0: ignored, stay IDLE.
- START (exactly 1 cycle):
  - core_start=run_mask; done_mask cleared to 0; wait counter cleared to 0.
  - Next state WAIT.
  - core_done is ignored in this cycle.
- WAIT:
  - Each cycle, nxt = done_mask | (core_done & run_mask); done_mask <= nxt.
  - Bits for disabled cores never set.
  - If nxt == run_mask: cycle_count <= cnt+1, all_done <= 1, go to DONE.
  - Else if cnt+1 == TIMEOUT_CYCLES: cycle_count <= cnt+1, timeout <= 1, go to DONE.
  - Else cnt <= cnt+1.
  - If completion and timeout are both met in the same cycle, completion wins: all_done=1, timeout=0.
- DONE (exactly 1 cycle):
  - all_done or timeout is high during this cycle only.
  - done_mask is frozen.
  - Next state IDLE.
- Timing:
  - Accepted launch in cycle N: phase=01 and core_start in cycle N+1. phase=10 from cycle N+2.
  - A core done in WAIT cycle M sets its done_mask bit in cycle M+1.
  - Minimum run (all cores done in the first WAIT cycle): phase sequence 01,10,11,00, with cycle_count=1.
- launch outside IDLE is ignored; it is not queued. core_done outside WAIT is ignored.
- busy = (phase != 00), registered together with phase.
- Counter never wraps, because the TIMEOUT_CYCLES bound is less than 2^CNT_W.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - localparams PHASE_IDLE=2'b00, PHASE_START=2'b01, PHASE_WAIT=2'b10, PHASE_DONE=2'b11;
  - default NUM_CORES.
  - The GPIO status block imports the same encoding.
- One natural sub-module: core_wait_timer.
  - Function: CNT_W counter with clear, enable and terminal-count output.
  - The FSM and done collection stay in core_dispatch_ctrl.

Test Plan:
- Config for all scenarios: NUM_CORES=4, TIMEOUT_CYCLES=16.
1. Reset: rst=1 for 3 cycles with launch=1 -> all outputs 0; phase=00 throughout; no core_start.
2. Normal run: core_enable=4'b1111, launch pulse at cycle 0, cores done in WAIT cycles 2,3,3,5 -> core_start=1111 at cycle 1 only; done_mask steps 0001,0111,1111; all_done pulse; cycle_count=5; phase returns to 00.
3. Partial mask: core_enable=4'b0101; core_done=4'b1111 in WAIT cycle 1 -> done_mask=0101; all_done; cycle_count=1; core_start=0101.
4. Timeout: core_enable=1111; only cores 0 and 1 respond -> timeout pulse after 16 WAIT cycles; cycle_count=16; done_mask=0011; all_done=0.
5. Simultaneous: last core done exactly in WAIT cycle 16 -> all_done=1, timeout=0, cycle_count=16.
6. Ignored requests and reset mid-run:
   - launch with core_enable=0 -> stays IDLE.
   - launch during WAIT -> no second core_start.
   - rst asserted in WAIT -> next cycle phase=00 and all outputs 0.
